bicubic_tap_feeder: RTL and testbench
=====================================

# bicubic_tap_feeder

Producer side of the bicubic kernel interface. It walks a row of output positions at a programmable Q8.8 step and fetches the four neighbour pixels P(-1)..P(2) from a synchronous-read source memory. It computes the Q0.8 power vector {x³, x², x, 1.0}, hands one tap set at a time to the kernel, and streams the returned 8-bit results out with an output index.

## Interface
Parameters:
- SRC_W, 16: source row length in pixels; legal range 4–65535.
- DST_W, 32: outputs per frame; legal range 1–256.
- AW, 16: source address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches a frame; ignored while busy.
- step  in  16  Q8.8 source increment per output; sampled on start.
- busy  out  1  high from the start edge until the cycle after frame_done.
- src_rd  out  1  source read strobe.
- src_addr  out  AW  source pixel address.
- src_data  in  8  read data; valid one cycle after src_rd.
- k_valid  out  1  tap set presented to the kernel.
- k_ready  in  1  kernel accepts the tap set when both k_valid and k_ready are high.
- k_x  out  32  {x³, x², x, 8'hFF}; k_x[31:24]=x³, k_x[7:0]=8'hFF.
- k_p  out  32  {P(-1), P(0), P(1), P(2)}; k_p[31:24]=P(-1).
- k_done  in  1  kernel result strobe.
- k_val  in  8  kernel result, sampled on k_done.
- out_valid  out  1  one-cycle result pulse.
- out_data  out  8  result.
- out_idx  out  8  output index 0..DST_W-1.
- frame_done  out  1  one-cycle pulse, coincident with the last out_valid.

## Operation
- States: IDLE → FETCH → ISSUE → WAIT → NEXT → FETCH, or NEXT → IDLE after the last output.
- IDLE:
  - pos is 24-bit Q16.8 and is 0 while in IDLE.
  - idx = 0.
  - On start: latch step, go to FETCH with tap counter cnt = 0.
- FETCH lasts 5 cycles, cnt 0..4:
  - n = pos[23:8], f = pos[7:0].
  - In cnt 0..3: src_rd=1, src_addr = tap index t(cnt) = n-1+cnt, computed signed.
  - In cnt 1..4: src_data is captured into P(cnt-1).
  - Powers, all with round-half-up multiply (a·b+128)>>8:
    - x = f.
    - x² = rnd(f·f), registered in cnt 0.
    - x³ = rnd(x²·f), registered in cnt 1.
- ISSUE: k_valid=1 and k_x/k_p held stable until k_ready is high; then go to WAIT.
- WAIT:
  - On k_done: out_data ← k_val, out_idx ← idx.
  - out_valid pulses in the following cycle.
  - A k_done pulse outside WAIT is ignored.
- NEXT (1 cycle):
  - If idx == DST_W-1: frame_done, go to IDLE.
  - Else: idx+1, pos += step, go to FETCH.
- pos does not wrap for legal parameters (255·0xFFFF < 2²⁴).
- Boundary taps: t < 0 or t > SRC_W-1. Handling is set by the configuration macro. An out-of-range tap never issues src_rd.
- step = 0: every output uses taps around pixel 0.
- start arriving in the same cycle as frame_done is ignored.

## Timing
- Reset values: every output is 0, state IDLE, k_x = 0, k_p = 0. Reset aborts a frame mid-flight immediately; no partial output follows.
- First k_valid: high in the cycle beginning 5 rising edges after the edge that samples start.
- Per output: 5 (FETCH) + ISSUE wait + WAIT wait + 1 (out_valid/NEXT overlap) cycles.
- With a kernel that sets k_ready=1 and returns k_done 5 cycles after acceptance, the period is 12 cycles per output.
- Source read latency is fixed at 1 cycle; there is no backpressure on src.
- k_x/k_p are stable for the whole of ISSUE and WAIT.

## Configuration
- BICUBIC_FEED_EDGE_CLAMP_EN:
  - Defined: an out-of-range tap index is clamped to 0 or SRC_W-1, and the read is issued at the clamped address. This is edge replication.
  - Undefined: an out-of-range tap gets P=0 and no read is issued for it.

## Structure
- bicubic_pkg holds:
  - the state enum (IDLE, FETCH, ISSUE, WAIT, NEXT);
  - ONE_Q08 = 8'hFF;
  - NUM_TAPS = 4;
  - the Q-format width constants (POS_W = 24, FRAC_W = 8).
- Sub-module bicubic_pow_unit: an 8×8 Q0.8 multiply with round-half-up, instantiated once and time-shared for x² and x³.

## Test plan
- Reset and idle:
  - Stimulus: rst low mid-FETCH.
  - Required: all outputs 0 and busy=0 immediately; after release, start runs a clean frame from idx 0.
- Integer step:
  - Stimulus: SRC_W=8, mem={10,20,…,80}, step=0x0100, DST_W=4, clamp on.
  - Required: output 0 has k_x=0x000000FF, k_p={10,10,20,30}; output 1 has k_p={10,20,30,40}.
- Half step, output 1:
  - Stimulus: step=0x0080.
  - Required: k_x={0x20,0x40,0x80,0xFF}, k_p={10,10,20,30}.
- Right edge:
  - Stimulus: step=0x0080, DST_W=16.
  - Required, output 15 (pos 7.5): with clamp, k_p={70,80,80,80}; without clamp, k_p={70,80,0,0} and no src_rd for addresses 8 or 9.
- Handshake:
  - Stimulus: k_ready held low for 7 cycles, then k_done with k_val=0x5A after 3 cycles.
  - Required: k_x/k_p stable throughout; a single out_valid with out_data=0x5A; a spurious k_done during FETCH is ignored.
- Frame end:
  - Stimulus: DST_W=3.
  - Required: frame_done coincides with out_valid at out_idx=2; busy drops the next cycle; start in the frame_done cycle is ignored.

Source files
------------

// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared states and Q-format constants for the bicubic tap feeder
package bicubic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    NEXT
  } state_e;

  localparam logic [7:0] ONE_Q08  = 8'hFF;
  localparam int         NUM_TAPS = 4;
  localparam int         POS_W    = 24;
  localparam int         FRAC_W   = 8;

endpackage

// File: rtl/bicubic_tap_feeder_if.sv
// rtl/bicubic_tap_feeder_if.sv - tap-set handshake between the feeder and the bicubic kernel
interface bicubic_tap_feeder_if;

  logic        k_valid;
  logic        k_ready;
  logic [31:0] k_x;
  logic [31:0] k_p;
  logic        k_done;
  logic [7:0]  k_val;

  modport master (output k_valid, k_x, k_p, input k_ready, k_done, k_val);
  modport slave  (input k_valid, k_x, k_p, output k_ready, k_done, k_val);

endinterface

// File: rtl/bicubic_pow_unit.sv
// rtl/bicubic_pow_unit.sv - Q0.8 x Q0.8 multiply with round-half-up, shared for x^2 and x^3
module bicubic_pow_unit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  // 255*255 + 128 still fits in 16 bits, so no carry is lost.
  assign y = 8'(({8'd0, a} * {8'd0, b} + 16'd128) >> 8);

endmodule

// File: rtl/bicubic_tap_feeder.sv
// rtl/bicubic_tap_feeder.sv - walks output positions, fetches 4 taps, feeds the bicubic kernel
// Edge replication of out-of-range taps when BICUBIC_FEED_EDGE_CLAMP_EN is defined.
module bicubic_tap_feeder
  import bicubic_pkg::*;
#(
  parameter int SRC_W = 16,
  parameter int DST_W = 32,
  parameter int AW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          step,
  output logic                 busy,
  output logic                 src_rd,
  output logic [AW-1:0]        src_addr,
  input  logic [7:0]           src_data,
  bicubic_tap_feeder_if.master kif,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [7:0]           out_idx,
  output logic                 frame_done
);

  localparam logic signed [17:0] MAX_T    = 18'(SRC_W - 1);
  localparam logic [7:0]         LAST_IDX = 8'(DST_W - 1);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [15:0]        step_q, step_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         x2_q, x2_d, x3_q, x3_d;
  logic [7:0]         p_q [NUM_TAPS];
  logic [7:0]         p_d [NUM_TAPS];
  logic [31:0]        kx_q, kx_d;
  logic               out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [7:0]         out_data_q, out_data_d, out_idx_q, out_idx_d;

  logic [FRAC_W-1:0]  frac;
  logic [7:0]         pow_a, pow_y;
  logic signed [17:0] t_rd, t_addr;
  logic               fetching;
  logic [7:0]         cap_val;
  logic [1:0]         cap_slot;

  function automatic logic in_range(input logic signed [17:0] t);
    return (t >= 18'sd0) && (t <= MAX_T);
  endfunction

  assign frac  = pos_q[FRAC_W-1:0];
  assign pow_a = (cnt_q == 3'd0) ? frac : x2_q;

  bicubic_pow_unit u_pow (
    .a (pow_a),
    .b (frac),
    .y (pow_y)
  );

  assign fetching = (state_q == FETCH);
  assign t_rd     = $signed({2'b00, pos_q[POS_W-1:FRAC_W]}) + $signed({15'd0, cnt_q}) - 18'sd1;
  assign cap_slot = 2'(cnt_q - 3'd1);

`ifdef BICUBIC_FEED_EDGE_CLAMP_EN
  assign t_addr  = (t_rd < 18'sd0) ? 18'sd0 : ((t_rd > MAX_T) ? MAX_T : t_rd);
  assign src_rd  = fetching && (cnt_q < 3'd4);
  assign cap_val = src_data;
`else
  // The tap captured now was addressed one cycle earlier; a skipped read yields zero.
  logic cap_in;
  assign t_addr  = t_rd;
  assign cap_in  = in_range(t_rd - 18'sd1);
  assign src_rd  = fetching && (cnt_q < 3'd4) && in_range(t_rd);
  assign cap_val = cap_in ? src_data : 8'd0;
`endif

  assign src_addr = src_rd ? AW'($unsigned(t_addr)) : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    step_d       = step_q;
    idx_d        = idx_q;
    x2_d         = x2_q;
    x3_d         = x3_q;
    p_d          = p_q;
    kx_d         = kx_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    case (state_q)
      IDLE: begin
        pos_d = '0;
        idx_d = '0;
        if (start) begin
          step_d  = step;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (cnt_q == 3'd0) x2_d = pow_y;
        if (cnt_q == 3'd1) x3_d = pow_y;
        if (cnt_q != 3'd0) p_d[cap_slot] = cap_val;
        if (cnt_q == 3'd4) begin
          kx_d    = {x3_q, x2_q, frac, ONE_Q08};
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ISSUE: begin
        if (kif.k_ready) state_d = WAIT;
      end
      WAIT: begin
        if (kif.k_done) begin
          out_data_d   = kif.k_val;
          out_idx_d    = idx_q;
          out_valid_d  = 1'b1;
          frame_done_d = (idx_q == LAST_IDX);
          state_d      = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          pos_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          pos_d   = pos_q + POS_W'(step_q);
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pos_q        <= '0;
      step_q       <= '0;
      idx_q        <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      kx_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      for (int i = 0; i < NUM_TAPS; i++) p_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      step_q       <= step_d;
      idx_q        <= idx_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      kx_q         <= kx_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      p_q          <= p_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign kif.k_valid = (state_q == ISSUE);
  assign kif.k_x     = kx_q;
  assign kif.k_p     = {p_q[0], p_q[1], p_q[2], p_q[3]};
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_bicubic_tap_feeder.sv
// tb/tb_bicubic_tap_feeder.sv - randomized bench for bicubic_tap_feeder against an arithmetic tap model
module tb_bicubic_tap_feeder;

  localparam int SRC_W = 8;
  localparam int DST_W = 16;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   step = '0;
  logic          busy;
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data = '0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [7:0]    out_idx;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int ov_cnt = 0, ov_exp = 0;
  int fd_cnt = 0, fd_exp = 0;
  int oob_rd = 0;

  logic [7:0]  mem [SRC_W];
  logic [15:0] rd_q [$];
  logic [15:0] steps [5];

  bicubic_tap_feeder_if kif ();

  bicubic_tap_feeder #(.SRC_W(SRC_W), .DST_W(DST_W), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step       (step),
    .busy       (busy),
    .src_rd     (src_rd),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .kif        (kif),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Source memory with one-cycle read latency; junk is returned when nothing was read.
  always @(posedge clk) begin
    if (src_rd) begin
      rd_q.push_back(src_addr);
      if (int'(src_addr) >= SRC_W) oob_rd++;
      src_data <= (int'(src_addr) < SRC_W) ? mem[src_addr[2:0]] : 8'hEE;
    end else begin
      src_data <= 8'hCC;
    end
    if (out_valid)  ov_cnt++;
    if (frame_done) fd_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_src_rd"}, src_rd, 0);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_k_valid"}, kif.k_valid, 0);
    chk({tag, "_k_x"}, kif.k_x, 0);
    chk({tag, "_k_p"}, kif.k_p, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic run_output(input int i, input logic [15:0] s, input int lat,
                            input int d, input int w, input logic [7:0] kv);
    int          n, pos, nn, f, x2, x3, t, unst;
    logic [7:0]  ep [4];
    logic [15:0] er [$];
    logic [31:0] kx0, kp0;
    pos = i * int'(s);
    nn  = pos / 256;
    f   = pos % 256;
    x2  = (f * f + 128) / 256;
    x3  = (x2 * f + 128) / 256;
    for (int k = 0; k < 4; k++) begin
      t = nn - 1 + k;
`ifdef BICUBIC_FEED_EDGE_CLAMP_EN
      if (t < 0) t = 0;
      if (t > SRC_W - 1) t = SRC_W - 1;
      ep[k] = mem[t];
      er.push_back(16'(t));
`else
      if (t >= 0 && t < SRC_W) begin
        ep[k] = mem[t];
        er.push_back(16'(t));
      end else begin
        ep[k] = 8'd0;
      end
`endif
    end

    n = 0;
    while (kif.k_valid !== 1'b1 && n < 40) begin
      kif.k_done = (n == 2);
      kif.k_val  = 8'hA5;
      @(negedge clk);
      n++;
    end
    kif.k_done = 1'b0;
    chk("k_valid_latency", n, lat);
    chk("out_valid_count", ov_cnt, ov_exp);
    chk("k_x", kif.k_x, {8'(x3), 8'(x2), 8'(f), 8'hFF});
    chk("k_p", kif.k_p, {ep[0], ep[1], ep[2], ep[3]});
    chk("src_rd_count", rd_q.size(), er.size());
    if (rd_q.size() == er.size())
      foreach (er[k]) chk("src_rd_addr", rd_q[k], er[k]);
    rd_q.delete();

    kx0  = kif.k_x;
    kp0  = kif.k_p;
    unst = 0;
    kif.k_ready = 1'b0;
    repeat (d) begin
      @(negedge clk);
      if (kif.k_valid !== 1'b1 || kif.k_x !== kx0 || kif.k_p !== kp0) unst++;
    end
    kif.k_ready = 1'b1;
    @(negedge clk);
    kif.k_ready = 1'b0;
    chk("k_valid_drop", kif.k_valid, 0);
    repeat (w) begin
      @(negedge clk);
      if (kif.k_x !== kx0 || kif.k_p !== kp0 || out_valid !== 1'b0) unst++;
    end
    kif.k_done = 1'b1;
    kif.k_val  = kv;
    @(negedge clk);
    kif.k_done = 1'b0;
    kif.k_val  = 8'($urandom);
    chk("hold_stable", unst, 0);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, kv);
    chk("out_idx", out_idx, i);
    chk("frame_done", frame_done, (i == DST_W - 1));
    chk("busy_in_frame", busy, 1);
    ov_exp++;
  endtask

  task automatic run_frame(input int fr, input logic [15:0] s);
    int         d, w;
    logic [7:0] kv;
    start = 1'b1;
    step  = s;
    @(negedge clk);
    start = 1'b0;
    step  = 16'($urandom);
    for (int i = 0; i < DST_W; i++) begin
      d  = $urandom_range(0, 3);
      w  = $urandom_range(0, 4);
      kv = 8'($urandom);
      if (fr == 1 && i == 1) begin
        d  = 7;
        w  = 2;
        kv = 8'h5A;
      end
      run_output(i, s, (i == 0) ? 5 : 6, d, w, kv);
    end
    fd_exp++;
    start = 1'b1;
    step  = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    repeat (7) @(negedge clk);
    chk("idle_after_done", {busy, kif.k_valid, src_rd}, 0);
    chk("out_valid_total", ov_cnt, ov_exp);
    chk("frame_done_total", fd_cnt, fd_exp);
    rd_q.delete();
  endtask

  initial begin
    kif.k_ready = 1'b0;
    kif.k_done  = 1'b0;
    kif.k_val   = 8'h00;
    for (int i = 0; i < SRC_W; i++) mem[i] = 8'(10 * (i + 1));

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    start = 1'b1;
    step  = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    chk("pre_abort_src_rd", src_rd, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    rd_q.delete();
    repeat (2) @(negedge clk);
    chk("abort_no_output", ov_cnt, 0);

    steps[0] = 16'h0100;
    steps[1] = 16'h0080;
    steps[2] = 16'h0000;
    steps[3] = 16'($urandom_range(1, 16'h01FF));
    steps[4] = 16'($urandom);
    for (int fr = 0; fr < 5; fr++) run_frame(fr, steps[fr]);

    chk("no_out_of_row_reads", oob_rd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
